// File: rtl/mem_pkg.sv
// Shared types and constants for the M-stage data-memory access controller:
// FSM state encoding, access-size codes, byte-mask table and alignment check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ_WAIT  = 2'd1,
        RESP_WAIT = 2'd2
    } mem_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Byte-enable pattern for an access of each size at lane 0.
    localparam logic [7:0] BYTE_MASK [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = (off[0] == 1'b0);
            SZ_W:    is_aligned = (off[1:0] == 2'b00);
            SZ_D:    is_aligned = (off == 3'b000);
            default: is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatting: store data shift and strobes, load data
// shift, truncation and sign/zero extension.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [63:0] st_data_i,
    input  logic [2:0]  st_off_i,
    input  logic [1:0]  st_size_i,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_wstrb_o,
    input  logic [63:0] ld_rdata_i,
    input  logic [2:0]  ld_off_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    output logic [63:0] ld_data_o
);

    logic [63:0] ld_shifted;

    assign st_wdata_o = st_data_i << {st_off_i, 3'b000};
    assign st_wstrb_o = BYTE_MASK[st_size_i] << st_off_i;

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = ld_shifted;
        case (ld_size_i)
            SZ_B:    ld_data_o = {{56{!ld_unsigned_i & ld_shifted[7]}},  ld_shifted[7:0]};
            SZ_H:    ld_data_o = {{48{!ld_unsigned_i & ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W:    ld_data_o = {{32{!ld_unsigned_i & ld_shifted[31]}}, ld_shifted[31:0]};
            SZ_D:    ld_data_o = ld_shifted;
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory sequencer: request/response FSM, pipeline stall/bubble,
// store/load formatting. Optional watchdog under MEM_STAGE_CTRL_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int XLEN = 64
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_is_load,
    input  logic            m_is_store,
    input  logic [1:0]      m_size,
    input  logic            m_unsigned,
    input  logic [XLEN-1:0] m_addr,
    input  logic [XLEN-1:0] m_wdata,
    input  logic            flush,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [7:0]      dmem_req_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,
    output logic            pipe_stall,
    output logic            regW_bubble,
    output logic [XLEN-1:0] load_data,
    output logic            load_data_valid,
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    output logic            bus_timeout,
`endif
    output logic            misalign_fault
);

    mem_state_e  state_q, state_d;
    logic        discard_q, discard_d;
    logic        latch_en;
    logic        we_q, load_q, uns_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q;
    logic [7:0]  wstrb_q;

    logic        mem_access, aligned, in_idle, mem_op, tmo_hit;
    logic [63:0] fmt_wdata, fmt_ld;
    logic [7:0]  fmt_wstrb;

    logic        valid_raw, we_raw, stall_raw, ld_valid_raw, fault_raw;
    logic [63:0] addr_raw, wdata_raw;
    logic [7:0]  wstrb_raw;

    assign mem_access = m_is_load | m_is_store;
    assign aligned    = is_aligned(m_size, m_addr[2:0]);
    assign in_idle    = (state_q == IDLE);
    assign mem_op     = in_idle & mem_access & aligned & !flush;

    mem_lane_fmt u_fmt (
        .st_data_i     (m_wdata),
        .st_off_i      (m_addr[2:0]),
        .st_size_i     (m_size),
        .st_wdata_o    (fmt_wdata),
        .st_wstrb_o    (fmt_wstrb),
        .ld_rdata_i    (dmem_resp_rdata),
        .ld_off_i      (addr_q[2:0]),
        .ld_size_i     (size_q),
        .ld_unsigned_i (uns_q),
        .ld_data_o     (fmt_ld)
    );

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = !in_idle && (tmo_cnt_q == 8'(TIMEOUT_CYCLES));

    // Count restarts on every entry into a wait state, including REQ_WAIT->RESP_WAIT.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_d != IDLE && state_d != state_q) tmo_cnt_d = '0;
        else if (!in_idle)                         tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end

    assign bus_timeout = rst & tmo_hit;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        latch_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    latch_en = 1'b1;
                    state_d  = dmem_req_ready ? RESP_WAIT : REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                discard_d = discard_q | flush;
                if (dmem_req_ready) state_d = RESP_WAIT;
            end
            RESP_WAIT: begin
                discard_d = discard_q | flush;
                if (dmem_resp_valid) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            state_d   = IDLE;
            discard_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (latch_en) begin
                we_q    <= m_is_store;
                load_q  <= m_is_load;
                uns_q   <= m_unsigned;
                size_q  <= m_size;
                addr_q  <= m_addr;
                wdata_q <= fmt_wdata;
                wstrb_q <= m_is_store ? fmt_wstrb : 8'h00;
            end
        end
    end

    // IDLE presents the request straight from the M-stage; REQ_WAIT replays the latched copy.
    always_comb begin
        valid_raw = 1'b0;
        we_raw    = 1'b0;
        addr_raw  = '0;
        wdata_raw = '0;
        wstrb_raw = '0;
        if (state_q == REQ_WAIT && !tmo_hit) begin
            valid_raw = 1'b1;
            we_raw    = we_q;
            addr_raw  = {addr_q[63:3], 3'b000};
            wdata_raw = wdata_q;
            wstrb_raw = wstrb_q;
        end else if (mem_op) begin
            valid_raw = 1'b1;
            we_raw    = m_is_store;
            addr_raw  = {m_addr[63:3], 3'b000};
            wdata_raw = fmt_wdata;
            wstrb_raw = m_is_store ? fmt_wstrb : 8'h00;
        end
    end

    assign stall_raw    = mem_op
                        | (((state_q == REQ_WAIT) | ((state_q == RESP_WAIT) & !dmem_resp_valid)) & !tmo_hit);
    assign ld_valid_raw = (state_q == RESP_WAIT) & dmem_resp_valid & load_q & !discard_q & !tmo_hit;
    assign fault_raw    = in_idle & mem_access & !aligned & !flush;

    // Outputs are forced low for the whole time reset is held, not just after the edge.
    assign dmem_req_valid  = rst & valid_raw;
    assign dmem_req_we     = rst & we_raw;
    assign dmem_req_addr   = rst ? addr_raw  : '0;
    assign dmem_req_wdata  = rst ? wdata_raw : '0;
    assign dmem_req_wstrb  = rst ? wstrb_raw : '0;
    assign pipe_stall      = rst & stall_raw;
    assign regW_bubble     = rst & stall_raw;
    assign load_data_valid = rst & ld_valid_raw;
    assign load_data       = (rst & ld_valid_raw) ? fmt_ld : '0;
    assign misalign_fault  = rst & fault_raw;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios with request and
// load-result scoreboards checked by a negedge monitor.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_is_load, m_is_store, m_unsigned, flush;
    logic [1:0]  m_size;
    logic [63:0] m_addr, m_wdata;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [63:0] dmem_req_addr, dmem_req_wdata;
    logic [7:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_rdata;
    logic        pipe_stall, regW_bubble, load_data_valid, misalign_fault;
    logic [63:0] load_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    req_t        req_sb[$];
    logic [63:0] ld_sb[$];
    req_t        exp_r;
    logic [63:0] exp_ld;

    mem_stage_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .m_is_load       (m_is_load),
        .m_is_store      (m_is_store),
        .m_size          (m_size),
        .m_unsigned      (m_unsigned),
        .m_addr          (m_addr),
        .m_wdata         (m_wdata),
        .flush           (flush),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .pipe_stall      (pipe_stall),
        .regW_bubble     (regW_bubble),
        .load_data       (load_data),
        .load_data_valid (load_data_valid),
        .misalign_fault  (misalign_fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && dmem_req_valid && dmem_req_ready) begin
            checks++;
            if (req_sb.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected addr=%h we=%b", dmem_req_addr, dmem_req_we);
            end else begin
                exp_r = req_sb.pop_front();
                if (dmem_req_addr !== exp_r.addr || dmem_req_we !== exp_r.we ||
                    dmem_req_wstrb !== exp_r.wstrb || (exp_r.we && dmem_req_wdata !== exp_r.wdata)) begin
                    errors++;
                    $display("FAIL req_fields got addr=%h we=%b wstrb=%h wdata=%h want addr=%h we=%b wstrb=%h wdata=%h",
                             dmem_req_addr, dmem_req_we, dmem_req_wstrb, dmem_req_wdata,
                             exp_r.addr, exp_r.we, exp_r.wstrb, exp_r.wdata);
                end
            end
        end
        if (load_data_valid) begin
            checks++;
            if (ld_sb.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected got=%h", load_data);
            end else begin
                exp_ld = ld_sb.pop_front();
                if (load_data !== exp_ld) begin
                    errors++;
                    $display("FAIL load_data got=%h want=%h", load_data, exp_ld);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m_is_load       = 1'b0;
        m_is_store      = 1'b0;
        m_size          = 2'd0;
        m_unsigned      = 1'b0;
        m_addr          = '0;
        m_wdata         = '0;
        flush           = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] a, input logic [63:0] wd);
        m_is_load  = ld;
        m_is_store = st;
        m_size     = sz;
        m_unsigned = uns;
        m_addr     = a;
        m_wdata    = wd;
    endtask

    task automatic push_req(input logic [63:0] a, input logic we, input logic [63:0] wd, input logic [7:0] ws);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd; r.wstrb = ws;
        req_sb.push_back(r);
    endtask

    task automatic test_reset();
        clear_in();
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h1000, 64'h0);
        dmem_req_ready = 1'b1;
        #12;
        checks++;
        if ({dmem_req_valid, pipe_stall, regW_bubble, load_data_valid, misalign_fault} !== 5'b0 ||
            dmem_req_addr !== 64'h0 || dmem_req_wstrb !== 8'h0 || load_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b stall=%b addr=%h want all 0",
                     dmem_req_valid, pipe_stall, dmem_req_addr);
        end
        cyc();
        clear_in();
        rst = 1'b1;
        cyc();
        #1;
        checks++;
        if ({dmem_req_valid, pipe_stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle got valid=%b stall=%b want 0 0", dmem_req_valid, pipe_stall);
        end
    endtask

    // One-cycle-ready, next-cycle-response load; returns to idle with inputs cleared.
    task automatic run_fast_load(input string nm, input logic [1:0] sz, input logic uns,
                                 input logic [63:0] a, input logic [63:0] rdata, input logic [63:0] want);
        set_op(1'b1, 1'b0, sz, uns, a, 64'hDEAD_BEEF_0000_0000);
        dmem_req_ready = 1'b1;
        push_req({a[63:3], 3'b000}, 1'b0, 64'h0, 8'h00);
        ld_sb.push_back(want);
        #1;
        checks++;
        if ({dmem_req_valid, pipe_stall, regW_bubble, dmem_req_wstrb} !== {3'b111, 8'h00}) begin
            errors++;
            $display("FAIL %s_issue got valid=%b stall=%b bubble=%b wstrb=%h want 1 1 1 00",
                     nm, dmem_req_valid, pipe_stall, regW_bubble, dmem_req_wstrb);
        end
        cyc();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        #1;
        checks++;
        if ({dmem_req_valid, pipe_stall, load_data_valid} !== 3'b001) begin
            errors++;
            $display("FAIL %s_resp got valid=%b stall=%b ldv=%b want 0 0 1",
                     nm, dmem_req_valid, pipe_stall, load_data_valid);
        end
        cyc();
        clear_in();
    endtask

    task automatic test_ld();
        run_fast_load("ld", 2'd3, 1'b0, 64'h1000, 64'h1122334455667788, 64'h1122334455667788);
        #1;
        checks++;
        if ({pipe_stall, dmem_req_valid, load_data_valid} !== 3'b000 || load_data !== 64'h0) begin
            errors++;
            $display("FAIL ld_after got stall=%b valid=%b ldv=%b data=%h want 0 0 0 0",
                     pipe_stall, dmem_req_valid, load_data_valid, load_data);
        end
    endtask

    task automatic test_lb();
        run_fast_load("lb_s", 2'd0, 1'b0, 64'h1003, 64'h0000000080000000, 64'hFFFFFFFFFFFFFF80);
        run_fast_load("lb_u", 2'd0, 1'b1, 64'h1003, 64'h0000000080000000, 64'h0000000000000080);
        run_fast_load("lh_s", 2'd1, 1'b0, 64'h1006, 64'h8001_0000_0000_0000, 64'hFFFFFFFFFFFF8001);
        run_fast_load("lw_u", 2'd2, 1'b1, 64'h1004, 64'hF234_5678_0000_0000, 64'h00000000F2345678);
    endtask

    task automatic test_sh_delay();
        set_op(1'b0, 1'b1, 2'd1, 1'b0, 64'h2006, 64'h0000_0000_0000_BEEF);
        push_req(64'h2000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0);
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            #1;
            checks++;
            if ({dmem_req_valid, dmem_req_we, pipe_stall} !== 3'b111 || dmem_req_addr !== 64'h2000 ||
                dmem_req_wstrb !== 8'hC0 || dmem_req_wdata !== 64'hBEEF_0000_0000_0000) begin
                errors++;
                $display("FAIL sh_hold_c%0d got valid=%b stall=%b addr=%h wstrb=%h wdata=%h want 1 1 2000 c0 beef000000000000",
                         i, dmem_req_valid, pipe_stall, dmem_req_addr, dmem_req_wstrb, dmem_req_wdata);
            end
            cyc();
            set_op(1'b0, 1'b1, 2'd3, 1'b0, 64'h5558, 64'h1234);
        end
        dmem_req_ready = 1'b0;
        #1;
        checks++;
        if ({dmem_req_valid, pipe_stall} !== 2'b01) begin
            errors++;
            $display("FAIL sh_resp_wait got valid=%b stall=%b want 0 1", dmem_req_valid, pipe_stall);
        end
        cyc();
        dmem_resp_valid = 1'b1;
        #1;
        checks++;
        if ({pipe_stall, load_data_valid} !== 2'b00) begin
            errors++;
            $display("FAIL sh_ack got stall=%b ldv=%b want 0 0", pipe_stall, load_data_valid);
        end
        cyc();
        clear_in();
    endtask

    task automatic test_misalign();
        set_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'h0);
        dmem_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({dmem_req_valid, misalign_fault, pipe_stall} !== 3'b010) begin
                errors++;
                $display("FAIL misalign_c%0d got valid=%b fault=%b stall=%b want 0 1 0",
                         i, dmem_req_valid, misalign_fault, pipe_stall);
            end
            cyc();
        end
        flush = 1'b1;
        #1;
        checks++;
        if ({dmem_req_valid, misalign_fault} !== 2'b00) begin
            errors++;
            $display("FAIL misalign_flush got valid=%b fault=%b want 0 0", dmem_req_valid, misalign_fault);
        end
        cyc();
        clear_in();
    endtask

    task automatic test_flush_drain();
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'h0);
        dmem_req_ready = 1'b1;
        push_req(64'h4000, 1'b0, 64'h0, 8'h00);
        cyc();
        clear_in();
        flush = 1'b1;
        #1;
        checks++;
        if (pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall0 got %b want 1", pipe_stall);
        end
        cyc();
        flush = 1'b0;
        #1;
        checks++;
        if (pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall1 got %b want 1", pipe_stall);
        end
        cyc();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        checks++;
        if ({pipe_stall, load_data_valid} !== 2'b00 || load_data !== 64'h0) begin
            errors++;
            $display("FAIL flush_drop got stall=%b ldv=%b data=%h want 0 0 0", pipe_stall, load_data_valid, load_data);
        end
        cyc();
        clear_in();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'h1;
        #1;
        checks++;
        if ({pipe_stall, dmem_req_valid, load_data_valid} !== 3'b000) begin
            errors++;
            $display("FAIL stray_resp got stall=%b valid=%b ldv=%b want 0 0 0",
                     pipe_stall, dmem_req_valid, load_data_valid);
        end
        cyc();
        clear_in();
    endtask

    task automatic test_back_to_back();
        run_fast_load("b2b_a", 2'd3, 1'b0, 64'h5000, 64'h0102030405060708, 64'h0102030405060708);
        run_fast_load("b2b_b", 2'd2, 1'b0, 64'h5008, 64'h0000_0000_8000_0001, 64'hFFFFFFFF80000001);
    endtask

    task automatic test_reset_mid();
        set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h6000, 64'h0);
        dmem_req_ready = 1'b1;
        push_req(64'h6000, 1'b0, 64'h0, 8'h00);
        cyc();
        dmem_req_ready = 1'b0;
        #1;
        checks++;
        if (pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got stall=%b want 1", pipe_stall);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({dmem_req_valid, pipe_stall, regW_bubble, load_data_valid, misalign_fault} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_async got valid=%b stall=%b bubble=%b want 0 0 0",
                     dmem_req_valid, pipe_stall, regW_bubble);
        end
        cyc();
        clear_in();
        rst = 1'b1;
        #1;
        checks++;
        if ({dmem_req_valid, pipe_stall} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_idle got valid=%b stall=%b want 0 0", dmem_req_valid, pipe_stall);
        end
        cyc();
        run_fast_load("rstmid_ld", 2'd3, 1'b0, 64'h6008, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888);
    endtask

    initial begin
        test_reset();
        test_ld();
        test_lb();
        test_sh_delay();
        test_misalign();
        test_flush_drain();
        test_back_to_back();
        test_reset_mid();
        cyc();
        checks++;
        if (req_sb.size() != 0 || ld_sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got req=%0d ld=%0d pending want 0 0", req_sb.size(), ld_sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
